exe_muldiv_unit: RTL
====================

// Module: exe_muldiv_unit
// PURPOSE
//  EX-stage multiply/divide unit with HI/LO registers. Sits directly downstream of the EX operand
//  forwarding muxes and consumes the forwarded SrcAE/SrcBE. MULT/MULTU finish in 2 cycles.
//  DIV/DIVU are iterative (radix-2 restoring, 34 cycles). BusyE stalls the pipeline through the hazard unit.
// PARAMETERS
//  DATA_W    32      operand / HI / LO width
//  DIV_ITERS DATA_W  number of restoring-division iterations (one quotient bit per cycle)
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high (`RESETABLE)
//  StartE     in   1       valid MulDivOpE in EX this cycle
//  MulDivOpE  in   3       `MD_NONE/`MD_MULT/`MD_MULTU/`MD_DIV/`MD_DIVU/`MD_MTHI/`MD_MTLO
//  FlushE     in   1       cancel in-flight op (exception/ERET); HI/LO not written
//  SrcAE      in   DATA_W  forwarded operand A (dividend / multiplicand / MTHI-MTLO data)
//  SrcBE      in   DATA_W  forwarded operand B (divisor / multiplier)
//  BusyE      out  1       stall request to hazard unit
//  DoneE      out  1       1-cycle pulse in the cycle HI/LO are written by MULT*/DIV*
//  HiOut      out  DATA_W  architectural HI (registered)
//  LoOut      out  DATA_W  architectural LO (registered)
// BEHAVIOUR
//  Reset: state=IDLE, HiOut=LoOut=`ZEROWORD, BusyE=0, DoneE=0, iteration counter=0.
//  FSM states: IDLE, MUL, DIV, FIX.
//  IDLE: if StartE && !FlushE:
//   - MULT/MULTU/DIV/DIVU: latch operands, signedness and operand signs; BusyE=1 combinationally in this cycle.
//   - MULT*: go to MUL. DIV*: load |A|, |B| (magnitudes when signed), clear remainder, go to DIV.
//   - MTHI/MTLO: write HiOut/LoOut <= SrcAE at the clock edge; no busy, stay IDLE.
//   - MD_NONE: no action.
//  MUL: 64-bit product of the latched operands (signed or unsigned) is written {HiOut,LoOut} at the end of the cycle.
//   BusyE=0 and DoneE=1 in this cycle, then go to IDLE. Total EX residency is 2 cycles.
//  DIV: one restoring step per cycle for DIV_ITERS cycles with BusyE=1; counter runs 0..DIV_ITERS-1, then go to FIX.
//  FIX: apply signs for signed ops. Quotient is negated iff the operand signs differ; remainder takes the sign of the dividend.
//   LoOut<=quotient, HiOut<=remainder. BusyE=0, DoneE=1, then go to IDLE. Total EX residency is 34 cycles.
//  Divide by zero (SrcBE==0, signed or unsigned): LoOut=32'hFFFF_FFFF, HiOut=original SrcAE. Still takes 34 cycles.
//  Signed 0x8000_0000 / 0xFFFF_FFFF: LoOut=0x8000_0000, HiOut=0. No trap.
//  Operands are latched at accept; SrcAE/SrcBE changes while busy are ignored.
//  StartE while not IDLE is ignored, because the stalled EX holds the same instruction.
//  FlushE in any state: go to IDLE next cycle, BusyE=0 in that cycle, HI/LO unchanged, DoneE=0.
//  FlushE together with StartE in IDLE: flush wins and nothing is accepted (MTHI/MTLO also suppressed).
//  reset overrides everything, including mid-division: all state returns to reset values.
// STRUCTURE
//  Shared package defines.vh: `DATALENGTH, `ZEROWORD, `RESETABLE (existing); add the `MD_* opcodes (3-bit)
//  and the FSM state encodings `MDS_IDLE/`MDS_MUL/`MDS_DIV/`MDS_FIX.
//  One sub-module: div_core. Holds the restoring iteration datapath (remainder/quotient shift registers and counter),
//  with a start/step interface and a last-iteration flag. The top level holds the FSM, sign handling, the multiplier and HI/LO.
// TESTING
//  1 MULT A=0xFFFF_FFFE(-2) B=3: BusyE=1 one cycle -> DoneE; {Hi,Lo}=0xFFFF_FFFF_FFFF_FFFA. MULTU same -> Hi=0x2, Lo=0xFFFF_FFFA.
//  2 DIV A=-7 B=2: BusyE=1 for exactly 33 cycles, DoneE in cycle 34; Lo=0xFFFF_FFFD(-3), Hi=0xFFFF_FFFF(-1).
//    DIVU 100/7 -> Lo=14, Hi=2.
//  3 DIVU A=0x1234 B=0 -> Lo=0xFFFF_FFFF, Hi=0x1234. DIV 0x8000_0000/-1 -> Lo=0x8000_0000, Hi=0.
//  4 MTHI 0xDEAD_BEEF then MTLO 0x0BAD_F00D on consecutive cycles: no BusyE; HiOut/LoOut updated the next cycle.
//  5 Start DIV, assert FlushE at iteration 10 -> IDLE next cycle, BusyE=0, HI/LO keep prior values.
//    A new MULT right after the flush completes normally.
//  6 reset pulse mid-DIV -> HiOut=LoOut=0, BusyE=0, DoneE=0. StartE+FlushE in IDLE with MTLO -> LoOut unchanged.

Source files
------------

// File: rtl/exe_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: widths, opcodes and FSM states.
package exe_muldiv_unit_pkg;

  localparam int unsigned DataLength = 32;
  localparam logic [DataLength-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6
  } mdOp_e;

  typedef enum logic [1:0] {
    MdsIdle = 2'd0,
    MdsMul  = 2'd1,
    MdsDiv  = 2'd2,
    MdsFix  = 2'd3
  } mdState_e;

  // True for the ops that occupy the unit and end with a DoneE pulse.
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// Pipeline-side handshake of the multiply/divide unit; the unit takes the slave modport.
interface exe_muldiv_unit_if
  import exe_muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DataLength
);
  logic              StartE;
  logic [2:0]        MulDivOpE;
  logic              FlushE;
  logic [DATA_W-1:0] SrcAE;
  logic [DATA_W-1:0] SrcBE;
  logic              BusyE;
  logic              DoneE;
  logic [DATA_W-1:0] HiOut;
  logic [DATA_W-1:0] LoOut;

  modport master (
    output StartE, MulDivOpE, FlushE, SrcAE, SrcBE,
    input  BusyE, DoneE, HiOut, LoOut
  );

  modport slave (
    input  StartE, MulDivOpE, FlushE, SrcAE, SrcBE,
    output BusyE, DoneE, HiOut, LoOut
  );
endinterface

// File: rtl/exe_muldiv_unit_div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient bit per step.
module exe_muldiv_unit_div_core #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_ITERS = DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              last
);

  localparam int unsigned CntW = $clog2(DIV_ITERS + 1);

  logic [DATA_W-1:0] remQ;
  logic [DATA_W-1:0] quoQ;
  logic [DATA_W-1:0] divisorQ;
  logic [CntW-1:0]   cntQ;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    shifted = {remQ, quoQ[DATA_W-1]};
    diff    = shifted - {1'b0, divisorQ};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remQ     <= '0;
      quoQ     <= '0;
      divisorQ <= '0;
      cntQ     <= '0;
    end else if (start) begin
      remQ     <= '0;
      quoQ     <= dividend;
      divisorQ <= divisor;
      cntQ     <= '0;
    end else if (step) begin
      if (!diff[DATA_W]) begin
        remQ <= diff[DATA_W-1:0];
        quoQ <= {quoQ[DATA_W-2:0], 1'b1};
      end else begin
        remQ <= shifted[DATA_W-1:0];
        quoQ <= {quoQ[DATA_W-2:0], 1'b0};
      end
      cntQ <= cntQ + 1'b1;
    end
  end

  assign quotient  = quoQ;
  assign remainder = remQ;
  assign last      = (cntQ == CntW'(DIV_ITERS - 1));

endmodule

// File: rtl/exe_muldiv_unit.sv
// EX-stage multiply/divide unit: 2-cycle MULT/MULTU, iterative DIV/DIVU, HI/LO registers.
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = DataLength,
  parameter int unsigned DIV_ITERS = DATA_W
) (
  input logic              clock,
  input logic              reset,
  exe_muldiv_unit_if.slave md
);

  mdState_e          stateQ;
  logic [DATA_W-1:0] hiQ;
  logic [DATA_W-1:0] loQ;
  logic [DATA_W-1:0] opAQ;
  logic [DATA_W-1:0] opBQ;
  logic              signedQ;
  logic              signAQ;
  logic              signBQ;
  logic              divZeroQ;

  mdOp_e             op;
  logic              accept;
  logic              opSigned;
  logic              divStart;
  logic              divStep;
  logic              divLast;
  logic [DATA_W-1:0] absA;
  logic [DATA_W-1:0] absB;
  logic [DATA_W-1:0] divQuo;
  logic [DATA_W-1:0] divRem;
  logic [DATA_W-1:0] fixQuo;
  logic [DATA_W-1:0] fixRem;
  logic [2*DATA_W-1:0] extA;
  logic [2*DATA_W-1:0] extB;
  logic [2*DATA_W-1:0] product;

  assign op       = mdOp_e'(md.MulDivOpE);
  assign accept   = (stateQ == MdsIdle) && md.StartE && !md.FlushE;
  assign opSigned = (op == MdMult) || (op == MdDiv);
  assign divStart = accept && ((op == MdDiv) || (op == MdDivu));
  assign divStep  = (stateQ == MdsDiv) && !md.FlushE;

  always_comb begin
    absA = (opSigned && md.SrcAE[DATA_W-1]) ? -md.SrcAE : md.SrcAE;
    absB = (opSigned && md.SrcBE[DATA_W-1]) ? -md.SrcBE : md.SrcBE;
  end

  // Sign-extend to full width so one unsigned multiply yields the correct low 2*DATA_W bits.
  always_comb begin
    extA    = {{DATA_W{signedQ & opAQ[DATA_W-1]}}, opAQ};
    extB    = {{DATA_W{signedQ & opBQ[DATA_W-1]}}, opBQ};
    product = extA * extB;
  end

  always_comb begin
    fixQuo = (signedQ && (signAQ ^ signBQ)) ? -divQuo : divQuo;
    fixRem = (signedQ && signAQ) ? -divRem : divRem;
    if (divZeroQ) begin
      fixQuo = '1;
      fixRem = opAQ;
    end
  end

  exe_muldiv_unit_div_core #(
    .DATA_W   (DATA_W),
    .DIV_ITERS(DIV_ITERS)
  ) divCore (
    .clock    (clock),
    .reset    (reset),
    .start    (divStart),
    .step     (divStep),
    .dividend (absA),
    .divisor  (absB),
    .quotient (divQuo),
    .remainder(divRem),
    .last     (divLast)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ   <= MdsIdle;
      hiQ      <= '0;
      loQ      <= '0;
      opAQ     <= '0;
      opBQ     <= '0;
      signedQ  <= 1'b0;
      signAQ   <= 1'b0;
      signBQ   <= 1'b0;
      divZeroQ <= 1'b0;
    end else if (md.FlushE) begin
      stateQ <= MdsIdle;
    end else begin
      case (stateQ)
        MdsIdle: begin
          if (md.StartE) begin
            if (isMulDiv(md.MulDivOpE)) begin
              opAQ     <= md.SrcAE;
              opBQ     <= md.SrcBE;
              signedQ  <= opSigned;
              signAQ   <= md.SrcAE[DATA_W-1];
              signBQ   <= md.SrcBE[DATA_W-1];
              divZeroQ <= (md.SrcBE == '0);
              stateQ   <= ((op == MdMult) || (op == MdMultu)) ? MdsMul : MdsDiv;
            end else if (op == MdMthi) begin
              hiQ <= md.SrcAE;
            end else if (op == MdMtlo) begin
              loQ <= md.SrcAE;
            end
          end
        end
        MdsMul: begin
          hiQ    <= product[2*DATA_W-1:DATA_W];
          loQ    <= product[DATA_W-1:0];
          stateQ <= MdsIdle;
        end
        MdsDiv: begin
          if (divLast) begin
            stateQ <= MdsFix;
          end
        end
        MdsFix: begin
          hiQ    <= fixRem;
          loQ    <= fixQuo;
          stateQ <= MdsIdle;
        end
        default: stateQ <= MdsIdle;
      endcase
    end
  end

  assign md.BusyE = !reset && !md.FlushE &&
                    ((accept && isMulDiv(md.MulDivOpE)) || (stateQ == MdsDiv));
  assign md.DoneE = !reset && !md.FlushE && ((stateQ == MdsMul) || (stateQ == MdsFix));
  assign md.HiOut = hiQ;
  assign md.LoOut = loQ;

endmodule
